// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and access-shape helpers for dmem_ctrl
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  function automatic logic f3_valid(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_valid = 1'b1;
      default:                        f3_valid = 1'b0;
    endcase
  endfunction

  // Unshifted lane mask for the access width; funct3[1:0] encodes the size.
  function automatic logic [3:0] base_be(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  endfunction

  function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
    crosses = ((f3[1:0] == 2'b01) && (off == 2'd3)) ||
              ((f3[1:0] == 2'b10) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word array with byte-enable writes and a one-cycle registered read
module dmem_bank #(
  parameter int WA_W = 8
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [3:0]      i_be,
  input  logic [WA_W-1:0] i_addr,
  input  logic [31:0]     i_wdata,
  input  logic            i_re,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [0:(1<<WA_W)-1];
  logic [31:0] r_rdata;

  // Contents are deliberately not reset; the read register only moves on i_re.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I data-memory controller: byte/half/word loads and stores,
// optional splitting of word-crossing accesses into two bank cycles.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WA_W = ADDR_W - 2;

  dmem_state_t       r_state;
  dmem_state_t       w_next;
  logic              r_ready;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic              r_split;
  logic [31:0]       r_lo;

  logic              w_accept;
  logic              w_req_cross;
  logic              w_req_err;
  logic [WA_W-1:0]   w_waddr0;
  logic [WA_W-1:0]   w_waddr1;
  logic [6:0]        w_be_sh;
  logic [63:0]       w_wd_sh;
  logic              w_bank_we;
  logic              w_bank_re;
  logic [3:0]        w_bank_be;
  logic [WA_W-1:0]   w_bank_addr;
  logic [31:0]       w_bank_wdata;
  logic [31:0]       w_bank_rdata;
  logic [31:0]       w_lo;
  logic [31:0]       w_dw;
  logic [31:0]       w_ext;

  assign w_accept    = req_valid && r_ready;
  assign w_req_cross = crosses(req_funct3, req_addr[1:0]);
  assign w_req_err   = !f3_valid(req_funct3) ||
                       (req_we && req_funct3[2]) ||
                       (!MISALIGN_SPLIT && w_req_cross);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_req_err ? RESP : FIRST;
      FIRST:   w_next = r_split ? SECOND : RESP;
      SECOND:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      r_split <= 1'b0;
      r_lo    <= 32'h0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == IDLE);
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_req_err;
        r_split <= w_req_cross && !w_req_err;
      end
      // Hold the lower word while the bank fetches the overflow word.
      if (r_state == SECOND) r_lo <= w_bank_rdata;
    end
  end

  // Second word address wraps naturally at the WA_W-bit width.
  assign w_waddr0 = r_addr[ADDR_W-1:2];
  assign w_waddr1 = w_waddr0 + {{(WA_W-1){1'b0}}, 1'b1};

  assign w_be_sh = 7'({3'b000, base_be(r_f3)} << r_addr[1:0]);
  assign w_wd_sh = {32'h0, r_wdata} << {r_addr[1:0], 3'b000};

  // Writes are gated by reset so an abandoned split store never touches its second word.
  assign w_bank_we    = !reset && r_we && !r_err &&
                        ((r_state == FIRST) || (r_state == SECOND));
  assign w_bank_re    = !r_we && ((r_state == FIRST) || (r_state == SECOND));
  assign w_bank_addr  = (r_state == SECOND) ? w_waddr1 : w_waddr0;
  assign w_bank_be    = (r_state == SECOND) ? {1'b0, w_be_sh[6:4]} : w_be_sh[3:0];
  assign w_bank_wdata = (r_state == SECOND) ? w_wd_sh[63:32] : w_wd_sh[31:0];

  dmem_bank #(
    .WA_W (WA_W)
  ) u_bank (
    .i_clk   (clk),
    .i_we    (w_bank_we),
    .i_be    (w_bank_be),
    .i_addr  (w_bank_addr),
    .i_wdata (w_bank_wdata),
    .i_re    (w_bank_re),
    .o_rdata (w_bank_rdata)
  );

  assign w_lo = r_split ? r_lo : w_bank_rdata;
  assign w_dw = 32'({w_bank_rdata, w_lo} >> {r_addr[1:0], 3'b000});

  always_comb begin
    w_ext = 32'h0;
    case (r_f3)
      F3_B:    w_ext = {{24{w_dw[7]}}, w_dw[7:0]};
      F3_H:    w_ext = {{16{w_dw[15]}}, w_dw[15:0]};
      F3_W:    w_ext = w_dw;
      F3_BU:   w_ext = {24'h0, w_dw[7:0]};
      F3_HU:   w_ext = {16'h0, w_dw[15:0]};
      default: w_ext = 32'h0;
    endcase
  end

  assign req_ready = r_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = (r_state == RESP) && r_err;
  assign rsp_rdata = ((r_state == RESP) && !r_err && !r_we) ? w_ext : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl (split and non-split instances)
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [9:0]  req_addr = 10'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_n = 1'b0, req_we_n = 1'b0;
  logic [2:0]  req_funct3_n = 3'b000;
  logic [9:0]  req_addr_n = 10'h0;
  logic [31:0] req_wdata_n = 32'h0;
  logic        req_ready_n, rsp_valid_n, rsp_err_n;
  logic [31:0] rsp_rdata_n;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(10), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_ctrl #(.ADDR_W(10), .MISALIGN_SPLIT(1'b0)) dut_ns (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_n), .req_ready(req_ready_n), .req_we(req_we_n),
    .req_funct3(req_funct3_n), .req_addr(req_addr_n), .req_wdata(req_wdata_n),
    .rsp_valid(rsp_valid_n), .rsp_rdata(rsp_rdata_n), .rsp_err(rsp_err_n)
  );

  // Issues one request at a negedge and returns the response latency in cycles (99 = none).
  task automatic do_req(input bit ns, input bit we, input logic [2:0] f3,
                        input logic [9:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err);
    int waitc;
    waitc = 0;
    while (!(ns ? req_ready_n : req_ready) && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL req_ready_timeout got 0 want 1 addr=%h", addr);
    end
    if (ns) begin
      req_valid_n = 1'b1; req_we_n = we; req_funct3_n = f3; req_addr_n = addr; req_wdata_n = wd;
    end else begin
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_valid_n = 1'b0;
    lat = 99; rd = 32'h0; err = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ns ? rsp_valid_n : rsp_valid) begin
        lat = i;
        rd  = ns ? rsp_rdata_n : rsp_rdata;
        err = ns ? rsp_err_n : rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, req_ready_n, rsp_valid_n} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000", {req_ready, rsp_valid, rsp_err, req_ready_n, rsp_valid_n});
    end
    n_cmp++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got %h want 00000000", rsp_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || req_ready_n !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset got %b%b want 11", req_ready, req_ready_n);
    end
  endtask

  task automatic test_aligned();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 1, 3'b010, 10'h010, 32'hDEADBEEF, lat, rd, err);
    n_cmp++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL sw_aligned got lat=%0d err=%b rd=%h want lat=2 err=0 rd=0", lat, err, rd);
    end
    do_req(0, 0, 3'b010, 10'h010, 32'h0, lat, rd, err);
    n_cmp++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_aligned got lat=%0d err=%b rd=%h want lat=2 err=0 rd=deadbeef", lat, err, rd);
    end
  endtask

  task automatic test_extend();
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b000};
    logic [9:0]  adrs [6] = '{10'h013, 10'h013, 10'h012, 10'h012, 10'h011, 10'h010};
    logic [31:0] exps [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD,
                              32'hFFFFADBE, 32'hFFFFFFEF};
    int lat; logic [31:0] rd; logic err;
    for (int i = 0; i < 6; i++) begin
      do_req(0, 0, f3s[i], adrs[i], 32'h0, lat, rd, err);
      n_cmp++;
      if (lat !== 2 || err !== 1'b0 || rd !== exps[i]) begin
        n_fail++;
        $display("FAIL load_ext[%0d] got lat=%0d err=%b rd=%h want lat=2 err=0 rd=%h", i, lat, err, rd, exps[i]);
      end
    end
  endtask

  task automatic test_split();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 1, 3'b010, 10'h020, 32'h0, lat, rd, err);
    do_req(0, 1, 3'b010, 10'h024, 32'h0, lat, rd, err);
    do_req(0, 1, 3'b010, 10'h021, 32'h11223344, lat, rd, err);
    n_cmp++;
    if (lat !== 3 || err !== 1'b0) begin
      n_fail++; $display("FAIL sw_split got lat=%0d err=%b want lat=3 err=0", lat, err);
    end
    do_req(0, 0, 3'b010, 10'h020, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'h22334400) begin
      n_fail++; $display("FAIL split_word0 got %h want 22334400", rd);
    end
    do_req(0, 0, 3'b010, 10'h024, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'h00000011) begin
      n_fail++; $display("FAIL split_word1 got %h want 00000011", rd);
    end
    do_req(0, 0, 3'b010, 10'h021, 32'h0, lat, rd, err);
    n_cmp++;
    if (lat !== 3 || err !== 1'b0 || rd !== 32'h11223344) begin
      n_fail++; $display("FAIL lw_split got lat=%0d err=%b rd=%h want lat=3 err=0 rd=11223344", lat, err, rd);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 1, 3'b010, 10'h3FC, 32'h0, lat, rd, err);
    do_req(0, 1, 3'b010, 10'h000, 32'h0, lat, rd, err);
    do_req(0, 1, 3'b001, 10'h3FF, 32'h0000ABCD, lat, rd, err);
    n_cmp++;
    if (lat !== 3 || err !== 1'b0) begin
      n_fail++; $display("FAIL sh_wrap got lat=%0d err=%b want lat=3 err=0", lat, err);
    end
    do_req(0, 0, 3'b101, 10'h3FF, 32'h0, lat, rd, err);
    n_cmp++;
    if (lat !== 3 || rd !== 32'h0000ABCD) begin
      n_fail++; $display("FAIL lhu_wrap got lat=%0d rd=%h want lat=3 rd=0000abcd", lat, rd);
    end
    do_req(0, 0, 3'b010, 10'h3FC, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'hCD000000) begin
      n_fail++; $display("FAIL wrap_top_word got %h want cd000000", rd);
    end
    do_req(0, 0, 3'b010, 10'h000, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'h000000AB) begin
      n_fail++; $display("FAIL wrap_word0 got %h want 000000ab", rd);
    end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic err;
    do_req(0, 0, 3'b011, 10'h010, 32'h0, lat, rd, err);
    n_cmp++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL err_f3_011 got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0", lat, err, rd);
    end
    do_req(0, 1, 3'b011, 10'h010, 32'hFFFFFFFF, lat, rd, err);
    n_cmp++;
    if (lat !== 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_st_011 got lat=%0d err=%b want lat=1 err=1", lat, err);
    end
    do_req(0, 1, 3'b100, 10'h010, 32'h00000012, lat, rd, err);
    n_cmp++;
    if (lat !== 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_st_100 got lat=%0d err=%b want lat=1 err=1", lat, err);
    end
    do_req(0, 0, 3'b010, 10'h010, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      n_fail++; $display("FAIL err_mem_kept got %h want deadbeef", rd);
    end
    do_req(1, 1, 3'b010, 10'h000, 32'h12345678, lat, rd, err);
    do_req(1, 0, 3'b010, 10'h002, 32'h0, lat, rd, err);
    n_cmp++;
    if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL ns_lw_misalign got lat=%0d err=%b rd=%h want lat=1 err=1 rd=0", lat, err, rd);
    end
    do_req(1, 1, 3'b010, 10'h002, 32'hFFFFFFFF, lat, rd, err);
    n_cmp++;
    if (lat !== 1 || err !== 1'b1) begin
      n_fail++; $display("FAIL ns_sw_misalign got lat=%0d err=%b want lat=1 err=1", lat, err);
    end
    do_req(1, 0, 3'b010, 10'h000, 32'h0, lat, rd, err);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h12345678) begin
      n_fail++; $display("FAIL ns_mem_kept got lat=%0d rd=%h want lat=2 rd=12345678", lat, rd);
    end
  endtask

  task automatic test_reset_mid_split();
    int lat; logic [31:0] rd; logic err; bit saw;
    do_req(0, 1, 3'b010, 10'h040, 32'h0, lat, rd, err);
    do_req(0, 1, 3'b010, 10'h044, 32'h55667788, lat, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h041; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_ctrl[%0d] got ready=%b valid=%b want 0 0", i, req_ready, rsp_valid);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_no_rsp got rsp_valid=1 want 0");
    end
    do_req(0, 0, 3'b010, 10'h040, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'hFEF00D00) begin
      n_fail++; $display("FAIL mid_reset_word0 got %h want fef00d00", rd);
    end
    do_req(0, 0, 3'b010, 10'h044, 32'h0, lat, rd, err);
    n_cmp++;
    if (rd !== 32'h55667788) begin
      n_fail++; $display("FAIL mid_reset_word1 got %h want 55667788", rd);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_extend();
    test_split();
    test_wrap();
    test_errors();
    test_reset_mid_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width; capacity is 2**ADDR_W bytes, organised as 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter MISALIGN_SPLIT, default 1, meaning 1 = split misaligned accesses into two word accesses, 0 = reject them with an error.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, controller can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3, RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle response pulse.
REQ-012 SHALL have port rsp_rdata, output, 32, load result; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1, request rejected; qualified by rsp_valid.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1, capturing we, funct3, addr and wdata.
REQ-015 SHALL drive req_ready=1 only in state IDLE, so at most one request is outstanding.
REQ-016 SHALL use FSM states IDLE, FIRST, SECOND and RESP.
REQ-017 SHALL follow IDLE->FIRST->RESP->IDLE for an aligned access, or an access fully inside one word.
REQ-018 SHALL follow IDLE->FIRST->SECOND->RESP->IDLE for an access that crosses a word boundary when MISALIGN_SPLIT=1.
- Crossing cases: H at byte offset 3; W at byte offset 1, 2 or 3.
REQ-019 SHALL go IDLE->RESP with rsp_err=1 and no memory change for any of these:
- funct3 values 011, 110 or 111;
- a store with funct3[2]=1;
- a crossing access when MISALIGN_SPLIT=0.
REQ-020 SHALL give rsp_valid a latency of 2 cycles after acceptance for aligned accesses, 3 for split accesses and 1 for errors; rsp_valid is held high exactly one cycle, in RESP.
REQ-021 SHALL perform stores as byte-enabled word writes.
- Data is shifted left by 8*offset; enables are 0001, 0011 or 1111 shifted by offset.
- In FIRST, lanes 0-3 go to word addr[ADDR_W-1:2]; in SECOND, overflow lanes 4-6 go to the next word.
REQ-022 SHALL compute the second word address modulo 2**(ADDR_W-2), so an access at the top word wraps to word 0.
REQ-023 SHALL assemble loads little-endian from the bytes at addr..addr+n-1.
- B and H are sign-extended from the top loaded byte; BU and HU are zero-extended.
REQ-024 SHALL make each response a pulse with no backpressure on rsp_valid.
REQ-025 SHALL not capture a req_valid asserted while not in IDLE; the requester holds it until req_ready is high.
REQ-026 SHALL not reset memory contents; the contents are undefined after power-up.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, force state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0; req_ready becomes 1 in the first cycle after reset deasserts.
REQ-028 SHALL, when reset occurs mid-operation, abandon the access with no response.
- A split store reset after FIRST keeps its first-word write; the second word is unchanged.
REQ-029 SHALL give reset priority over a simultaneous request acceptance.

Structure
REQ-030 SHALL place in shared package dmem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum dmem_state_t.
REQ-031 SHALL instantiate one sub-module, dmem_bank: a word array with 4-bit byte-enable write and 1-cycle registered read, parameterised by word-address width.

Verification
REQ-032 SHALL cover aligned word store/load: SW 0xDEADBEEF at 0x010, then LW 0x010 -> rsp_rdata=0xDEADBEEF two cycles after accept, rsp_err=0.
REQ-033 SHALL cover byte sign and zero extension: after REQ-032, LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x012 -> 0x0000DEAD.
REQ-034 SHALL cover a split store and load: SW 0x11223344 at 0x021 -> words 0x020=0x223344xx and 0x024=0xxxxxxx11; LW 0x021 -> 0x11223344; both responses 3 cycles after accept.
REQ-035 SHALL cover wrap-around: ADDR_W=10, SH 0xABCD at 0x3FF -> byte 0x3FF=0xCD, byte 0x000=0xAB; LHU 0x3FF -> 0x0000ABCD.
REQ-036 SHALL cover error cases, each giving rsp_err=1 one cycle after accept and memory unchanged:
- funct3=011;
- a store with funct3=100;
- MISALIGN_SPLIT=0 with LW 0x002.
REQ-037 SHALL cover reset mid-split: assert reset in SECOND of SW 0xCAFEF00D at 0x041 -> no rsp_valid, req_ready=0 during reset, first word written, word 0x044 unchanged.
